// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipe scroller: FSM states, coordinate widths
// and the LFSR-to-gap-height mapping.
package pipe_pkg;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_WAIT, S_MOVE} state_t;

  localparam int X_W  = 11;
  localparam int Y_W  = 9;
  // Stored X needs one extra bit: freshly seeded slots reach 1088, beyond 11-bit signed.
  localparam int XI_W = X_W + 1;

  function automatic logic [Y_W-1:0] gap_map(input logic [4:0] rnd,
                                             input int gap_min,
                                             input int gap_step);
    logic [Y_W-1:0] scaled;
    scaled = Y_W'(rnd) * Y_W'(gap_step);
    return Y_W'(gap_min) + scaled;
  endfunction

endpackage

// File: rtl/pipe_slot_update.sv
// Combinational per-frame update of one pipe slot: scroll, wrap-around respawn
// with a fresh gap height, and bird-pass detection.
module pipe_slot_update
  import pipe_pkg::*;
#(
  parameter int PIPE_W     = 52,
  parameter int SPEED      = 2,
  parameter int WRAP_DIST  = 672,
  parameter int BIRD_X     = 160,
  parameter int GAP_Y_MIN  = 80,
  parameter int GAP_STEP   = 8
) (
  input  logic signed [XI_W-1:0] cur_x,
  input  logic        [4:0]      rand_val,
  output logic signed [XI_W-1:0] new_x,
  output logic        [Y_W-1:0]  new_y,
  output logic                   wrap,
  output logic                   score
);

  localparam logic signed [XI_W-1:0] SPEED_S  = XI_W'(SPEED);
  localparam logic signed [XI_W-1:0] PIPE_W_S = XI_W'(PIPE_W);
  localparam logic signed [XI_W-1:0] NEG_W_S  = -XI_W'(PIPE_W);
  localparam logic signed [XI_W-1:0] WRAP_S   = XI_W'(WRAP_DIST);
  localparam logic signed [XI_W-1:0] BIRD_S   = XI_W'(BIRD_X);

  logic signed [XI_W-1:0] moved_x;

  always_comb begin
    moved_x = cur_x - SPEED_S;
    wrap    = moved_x < NEG_W_S;
    new_x   = wrap ? (moved_x + WRAP_S) : moved_x;
    new_y   = gap_map(rand_val, GAP_Y_MIN, GAP_STEP);
    // Score only on the frame where the trailing edge crosses the bird column.
    score   = ((cur_x + PIPE_W_S) >= BIRD_S) && ((moved_x + PIPE_W_S) < BIRD_S);
  end

endmodule

// File: rtl/pipe_scroller.sv
// Seeds and scrolls N pipe slots once per frame tick, one slot per clock,
// respawning off-screen pipes and pulsing a score when a pipe passes the bird.
module pipe_scroller
  import pipe_pkg::*;
#(
  parameter int N_PIPES      = 3,
  parameter int SCREEN_W     = 640,
  parameter int PIPE_SPACING = 224,
  parameter int PIPE_W       = 52,
  parameter int SPEED        = 2,
  parameter int GAP_Y_MIN    = 80,
  parameter int GAP_STEP     = 8,
  parameter int BIRD_X       = 160
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic                   i_Freeze,
  input  logic                   i_Frame_Tick,
  input  logic [4:0]             i_LFSR_Data,
  output logic [N_PIPES*X_W-1:0] o_Pipe_X,
  output logic [N_PIPES*Y_W-1:0] o_Gap_Y,
  output logic                   o_Ready,
  output logic                   o_Score
);

  localparam int IDX_W = (N_PIPES > 1) ? $clog2(N_PIPES) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(N_PIPES - 1);
  localparam logic signed [XI_W-1:0] RESET_X  = XI_W'(SCREEN_W);
  localparam logic [Y_W-1:0]         RESET_Y  = Y_W'(GAP_Y_MIN);

  state_t                 state;
  logic [IDX_W-1:0]       slot_idx;
  logic signed [XI_W-1:0] pos_x [N_PIPES];
  logic [Y_W-1:0]         gap_y [N_PIPES];

  logic signed [XI_W-1:0] seed_x;
  logic signed [XI_W-1:0] upd_x;
  logic [Y_W-1:0]         upd_y;
  logic                   upd_wrap;
  logic                   upd_score;
  logic                   last_slot;

  assign seed_x    = XI_W'(SCREEN_W) + XI_W'(PIPE_SPACING) * XI_W'(slot_idx);
  assign last_slot = (slot_idx == LAST_IDX);

  // A single update datapath serves every slot, selected by slot_idx.
  pipe_slot_update #(
    .PIPE_W    (PIPE_W),
    .SPEED     (SPEED),
    .WRAP_DIST (N_PIPES * PIPE_SPACING),
    .BIRD_X    (BIRD_X),
    .GAP_Y_MIN (GAP_Y_MIN),
    .GAP_STEP  (GAP_STEP)
  ) u_update (
    .cur_x    (pos_x[slot_idx]),
    .rand_val (i_LFSR_Data),
    .new_x    (upd_x),
    .new_y    (upd_y),
    .wrap     (upd_wrap),
    .score    (upd_score)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state    <= S_IDLE;
      slot_idx <= '0;
      o_Ready  <= 1'b0;
      o_Score  <= 1'b0;
      for (int k = 0; k < N_PIPES; k++) begin
        pos_x[k] <= RESET_X;
        gap_y[k] <= RESET_Y;
      end
    end else begin
      o_Score <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_Start) begin
            state    <= S_INIT;
            slot_idx <= '0;
          end
        end
        S_INIT: begin
          pos_x[slot_idx] <= seed_x;
          gap_y[slot_idx] <= gap_map(i_LFSR_Data, GAP_Y_MIN, GAP_STEP);
          if (last_slot) begin
            state    <= S_WAIT;
            slot_idx <= '0;
            o_Ready  <= 1'b1;
          end else begin
            slot_idx <= slot_idx + 1'b1;
          end
        end
        S_WAIT: begin
          // Start takes priority over a coincident tick.
          if (i_Start) begin
            state    <= S_INIT;
            slot_idx <= '0;
            o_Ready  <= 1'b0;
          end else if (i_Frame_Tick && !i_Freeze) begin
            state    <= S_MOVE;
            slot_idx <= '0;
            o_Ready  <= 1'b0;
          end
        end
        S_MOVE: begin
          if (i_Start) begin
            state    <= S_INIT;
            slot_idx <= '0;
          end else begin
            pos_x[slot_idx] <= upd_x;
            if (upd_wrap) gap_y[slot_idx] <= upd_y;
            o_Score <= upd_score;
            if (last_slot) begin
              state    <= S_WAIT;
              slot_idx <= '0;
              o_Ready  <= 1'b1;
            end else begin
              slot_idx <= slot_idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_PIPES; k++) begin : g_out
    assign o_Pipe_X[X_W*k +: X_W] = pos_x[k][X_W-1:0];
    assign o_Gap_Y[Y_W*k +: Y_W]  = gap_y[k];
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: seeding, scrolling, scoring, wrap-around,
// freeze, start priority/abort and mid-move reset.
module tb_pipe_scroller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, freeze, tick;
  logic [4:0]  lfsr;
  logic [32:0] pipe_x;
  logic [26:0] gap_y;
  logic        ready, score;

  int checks   = 0;
  int failures = 0;

  pipe_scroller dut (
    .i_Clk        (clk),
    .i_Reset      (reset),
    .i_Start      (start),
    .i_Freeze     (freeze),
    .i_Frame_Tick (tick),
    .i_LFSR_Data  (lfsr),
    .o_Pipe_X     (pipe_x),
    .o_Gap_Y      (gap_y),
    .o_Ready      (ready),
    .o_Score      (score)
  );

  function automatic logic [10:0] px(input int k);
    return pipe_x[11*k +: 11];
  endfunction

  function automatic logic [8:0] gy(input int k);
    return gap_y[9*k +: 9];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame tick, waiting (bounded) for o_Ready and counting score pulses.
  task automatic do_tick(input logic [4:0] rnd, output int pulses);
    int waited;
    pulses = 0;
    lfsr = rnd;
    tick = 1'b1;
    step();
    tick = 1'b0;
    waited = 0;
    while (ready !== 1'b1 && waited < 10) begin
      if (score === 1'b1) pulses++;
      step();
      waited++;
    end
    if (score === 1'b1) pulses++;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL tick_timeout got ready=%b want=1", ready);
    end
  endtask

  task automatic init_seq();
    lfsr = 5'd0;  step();
    lfsr = 5'd5;  step();
    lfsr = 5'd31; step();
  endtask

  task automatic test_reset();
    int ex[3] = '{640, 640, 640};
    reset = 1'b1; start = 1'b0; freeze = 1'b0; tick = 1'b0; lfsr = 5'd0;
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b want=0", ready); end
    checks++;
    if (score !== 1'b0) begin failures++; $display("[TB] FAIL reset_score got=%b want=0", score); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (px(k) !== 11'(ex[k])) begin failures++; $display("[TB] FAIL reset_x%0d got=%0d want=%0d", k, px(k), ex[k]); end
      checks++;
      if (gy(k) !== 9'd80) begin failures++; $display("[TB] FAIL reset_y%0d got=%0d want=80", k, gy(k)); end
    end
  endtask

  task automatic test_init();
    int ex[3] = '{640, 864, 1088};
    int ey[3] = '{80, 120, 328};
    start = 1'b1; step(); start = 1'b0;
    lfsr = 5'd0; step();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("[TB] FAIL init_busy got=%b want=0", ready); end
    lfsr = 5'd5; step();
    lfsr = 5'd31; step();
    checks++;
    if (ready !== 1'b1) begin failures++; $display("[TB] FAIL init_ready got=%b want=1", ready); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (px(k) !== 11'(ex[k])) begin failures++; $display("[TB] FAIL init_x%0d got=%0d want=%0d", k, px(k), ex[k]); end
      checks++;
      if (gy(k) !== 9'(ey[k])) begin failures++; $display("[TB] FAIL init_y%0d got=%0d want=%0d", k, gy(k), ey[k]); end
    end
  endtask

  task automatic test_single_tick();
    int ex[3] = '{638, 862, 1086};
    int ey[3] = '{80, 120, 328};
    lfsr = 5'd7;
    tick = 1'b1; step(); tick = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (ready !== 1'b0) begin failures++; $display("[TB] FAIL move_busy%0d got=%b want=0", c, ready); end
      step();
    end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("[TB] FAIL move_ready got=%b want=1", ready); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (px(k) !== 11'(ex[k])) begin failures++; $display("[TB] FAIL tick1_x%0d got=%0d want=%0d", k, px(k), ex[k]); end
      checks++;
      if (gy(k) !== 9'(ey[k])) begin failures++; $display("[TB] FAIL tick1_y%0d got=%0d want=%0d", k, gy(k), ey[k]); end
    end
  endtask

  task automatic test_score();
    int early, p;
    early = 0;
    for (int t = 2; t <= 266; t++) begin
      do_tick(5'd7, p);
      early += p;
    end
    checks++;
    if (early !== 0) begin failures++; $display("[TB] FAIL score_early got=%0d want=0", early); end
    checks++;
    if (px(0) !== 11'd108) begin failures++; $display("[TB] FAIL score_pre_x0 got=%0d want=108", px(0)); end
    do_tick(5'd7, p);
    checks++;
    if (p !== 1) begin failures++; $display("[TB] FAIL score_pulse got=%0d want=1", p); end
    checks++;
    if (px(0) !== 11'd106) begin failures++; $display("[TB] FAIL score_post_x0 got=%0d want=106", px(0)); end
  endtask

  task automatic test_wrap();
    int ex[3] = '{618, 170, 394};
    int ey[3] = '{176, 120, 328};
    int extra, p;
    extra = 0;
    for (int t = 268; t <= 346; t++) begin
      do_tick(5'd7, p);
      extra += p;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("[TB] FAIL wrap_no_score got=%0d want=0", extra); end
    checks++;
    if (px(0) !== 11'(-52)) begin failures++; $display("[TB] FAIL wrap_pre_x0 got=%0d want=%0d", px(0), 11'(-52)); end
    do_tick(5'd12, p);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (px(k) !== 11'(ex[k])) begin failures++; $display("[TB] FAIL wrap_x%0d got=%0d want=%0d", k, px(k), ex[k]); end
      checks++;
      if (gy(k) !== 9'(ey[k])) begin failures++; $display("[TB] FAIL wrap_y%0d got=%0d want=%0d", k, gy(k), ey[k]); end
    end
  endtask

  task automatic test_freeze();
    int ex[3] = '{618, 170, 394};
    int em[3] = '{616, 168, 392};
    int bad_ready, p;
    bad_ready = 0;
    freeze = 1'b1;
    lfsr = 5'd3;
    for (int t = 0; t < 10; t++) begin
      tick = 1'b1; step(); tick = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (ready !== 1'b1) bad_ready++;
        if (c < 3) step();
      end
    end
    checks++;
    if (bad_ready !== 0) begin failures++; $display("[TB] FAIL freeze_ready got=%0d low samples want=0", bad_ready); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (px(k) !== 11'(ex[k])) begin failures++; $display("[TB] FAIL freeze_x%0d got=%0d want=%0d", k, px(k), ex[k]); end
    end
    checks++;
    if (gy(0) !== 9'd176) begin failures++; $display("[TB] FAIL freeze_y0 got=%0d want=176", gy(0)); end
    freeze = 1'b0;
    do_tick(5'd3, p);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (px(k) !== 11'(em[k])) begin failures++; $display("[TB] FAIL unfreeze_x%0d got=%0d want=%0d", k, px(k), em[k]); end
    end
  endtask

  task automatic test_start_wins();
    int ex[3] = '{640, 864, 1088};
    int ey[3] = '{80, 120, 328};
    start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("[TB] FAIL start_wins_busy got=%b want=0", ready); end
    init_seq();
    checks++;
    if (ready !== 1'b1) begin failures++; $display("[TB] FAIL start_wins_ready got=%b want=1", ready); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (px(k) !== 11'(ex[k])) begin failures++; $display("[TB] FAIL start_wins_x%0d got=%0d want=%0d", k, px(k), ex[k]); end
      checks++;
      if (gy(k) !== 9'(ey[k])) begin failures++; $display("[TB] FAIL start_wins_y%0d got=%0d want=%0d", k, gy(k), ey[k]); end
    end
  endtask

  task automatic test_abort_start();
    int ex[3] = '{640, 864, 1088};
    int ey[3] = '{80, 120, 328};
    lfsr = 5'd9;
    tick = 1'b1; step(); tick = 1'b0;
    step();
    checks++;
    if (px(0) !== 11'd638) begin failures++; $display("[TB] FAIL abort_pre_x0 got=%0d want=638", px(0)); end
    start = 1'b1; step(); start = 1'b0;
    init_seq();
    checks++;
    if (ready !== 1'b1) begin failures++; $display("[TB] FAIL abort_ready got=%b want=1", ready); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (px(k) !== 11'(ex[k])) begin failures++; $display("[TB] FAIL abort_x%0d got=%0d want=%0d", k, px(k), ex[k]); end
      checks++;
      if (gy(k) !== 9'(ey[k])) begin failures++; $display("[TB] FAIL abort_y%0d got=%0d want=%0d", k, gy(k), ey[k]); end
    end
  endtask

  task automatic test_reset_mid_move();
    lfsr = 5'd17;
    tick = 1'b1; step(); tick = 1'b0;
    step();
    reset = 1'b1; step(); reset = 1'b0;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_move_ready got=%b want=0", ready); end
    checks++;
    if (score !== 1'b0) begin failures++; $display("[TB] FAIL rst_move_score got=%b want=0", score); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (px(k) !== 11'd640) begin failures++; $display("[TB] FAIL rst_move_x%0d got=%0d want=640", k, px(k)); end
      checks++;
      if (gy(k) !== 9'd80) begin failures++; $display("[TB] FAIL rst_move_y%0d got=%0d want=80", k, gy(k)); end
    end
    tick = 1'b1; step(); tick = 1'b0;
    step(); step(); step(); step();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("[TB] FAIL idle_tick_ready got=%b want=0", ready); end
    checks++;
    if (px(0) !== 11'd640) begin failures++; $display("[TB] FAIL idle_tick_x0 got=%0d want=640", px(0)); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_tick();
    test_score();
    test_wrap();
    test_freeze();
    test_start_wins();
    test_abort_start();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
